// File: rtl/device_cmd_scheduler.sv
// device_cmd_scheduler: turns button rising edges into queued commands and issues them
// one at a time to the selected device over a req/ack handshake, with an ack timeout.
module device_cmd_scheduler #(
    parameter int unsigned NUM_DEV     = 4,
    parameter int unsigned SEL_W       = 2,
    parameter int unsigned DIGIT_W     = 7,
    parameter int unsigned FIFO_DEPTH  = 4,
    parameter int unsigned ACK_TIMEOUT = 15
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic [SEL_W-1:0]              device_choice,
    input  logic [DIGIT_W-1:0]            digit_choice,
    input  logic                          digit_load,
    input  logic                          digit_change,
    input  logic                          mode_change,
    output logic [NUM_DEV-1:0]            dev_req,
    output logic [1:0]                    dev_op,
    output logic [DIGIT_W-1:0]            dev_digit,
    input  logic [NUM_DEV-1:0]            dev_ack,
    output logic                          cmd_dropped,
    output logic                          ack_timeout,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_count,
    output logic                          busy,
    output logic                          digit_load_indicator
);

    localparam int unsigned PTR_W = $clog2(FIFO_DEPTH);
    localparam int unsigned CNT_W = PTR_W + 1;
    localparam int unsigned TMO_W = $clog2(ACK_TIMEOUT + 1);

    localparam logic [1:0] OP_LOAD   = 2'b00;
    localparam logic [1:0] OP_CHANGE = 2'b01;
    localparam logic [1:0] OP_MODE   = 2'b10;

    typedef struct packed {
        logic [1:0]         op;
        logic [SEL_W-1:0]   dev;
        logic [DIGIT_W-1:0] digit;
    } cmd_t;

    typedef enum logic {
        S_IDLE = 1'b0,
        S_REQ  = 1'b1
    } state_t;

    // button history and queue storage
    logic [2:0]         r_btn_hist;
    cmd_t               r_mem [FIFO_DEPTH];
    logic [PTR_W-1:0]   r_wr_ptr;
    logic [PTR_W-1:0]   r_rd_ptr;
    logic [CNT_W-1:0]   r_count;

    // dispatcher state
    state_t             r_state;
    logic [TMO_W-1:0]   r_tmo_cnt;
    logic [SEL_W-1:0]   r_dev_sel;
    logic [NUM_DEV-1:0] r_dev_req;
    logic [1:0]         r_dev_op;
    logic [DIGIT_W-1:0] r_dev_digit;

    // registered status outputs
    logic               r_cmd_dropped;
    logic               r_ack_timeout;
    logic               r_busy;
    logic               r_dli;

    // combinational helpers
    logic [2:0]         w_btn;
    logic [2:0]         w_rise;
    logic               w_any_rise;
    logic               w_multi_rise;
    logic               w_full;
    logic               w_push;
    logic               w_pop;
    logic [CNT_W-1:0]   w_count_nxt;
    cmd_t               w_new_cmd;
    cmd_t               w_head;
    state_t             w_state_nxt;
    logic [TMO_W-1:0]   w_tmo_inc;
    logic [TMO_W-1:0]   w_tmo_nxt;
    logic               w_timeout_hit;
    logic [SEL_W-1:0]   w_dev_sel_nxt;
    logic [NUM_DEV-1:0] w_req_nxt;
    logic [1:0]         w_op_nxt;
    logic [DIGIT_W-1:0] w_digit_nxt;

    // Event detection: bit order is {mode, load, change}
    assign w_btn        = {mode_change, digit_load, digit_change};
    assign w_rise       = w_btn & ~r_btn_hist;
    assign w_any_rise   = (w_rise != 3'd0);
    assign w_multi_rise = ((w_rise & (w_rise - 3'd1)) != 3'd0);
    assign w_full       = (r_count == CNT_W'(FIFO_DEPTH));
    assign w_push       = w_any_rise && !w_full;
    assign w_head       = r_mem[r_rd_ptr];
    assign w_count_nxt  = r_count + CNT_W'(w_push) - CNT_W'(w_pop);
    assign w_tmo_inc    = r_tmo_cnt + TMO_W'(1);

    // Winning event builds the queue entry; mode beats load beats change
    always_comb begin
        w_new_cmd       = '0;
        w_new_cmd.dev   = device_choice;
        w_new_cmd.digit = digit_choice;
        if (w_rise[2]) begin
            w_new_cmd.op = OP_MODE;
        end else if (w_rise[1]) begin
            w_new_cmd.op = OP_LOAD;
        end else begin
            w_new_cmd.op = OP_CHANGE;
        end
    end

    // Button history; forced high in reset so held buttons do not fire on release of reset
    always_ff @(posedge clk) begin
        if (rst) begin
            r_btn_hist <= '1;
        end else begin
            r_btn_hist <= w_btn;
        end
    end

    // Queue storage write port
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= w_new_cmd;
        end
    end

    // Queue pointers and occupancy
    always_ff @(posedge clk) begin
        if (rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + PTR_W'(1);
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + PTR_W'(1);
            end
            r_count <= w_count_nxt;
        end
    end

    // Dispatcher state register
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Dispatcher next-state and handshake outputs
    always_comb begin
        w_state_nxt   = r_state;
        w_pop         = 1'b0;
        w_tmo_nxt     = r_tmo_cnt;
        w_timeout_hit = 1'b0;
        w_dev_sel_nxt = r_dev_sel;
        w_req_nxt     = r_dev_req;
        w_op_nxt      = r_dev_op;
        w_digit_nxt   = r_dev_digit;
        case (r_state)
            S_IDLE: begin
                if (r_count != '0) begin
                    w_state_nxt   = S_REQ;
                    w_pop         = 1'b1;
                    w_tmo_nxt     = '0;
                    w_dev_sel_nxt = w_head.dev;
                    w_req_nxt     = NUM_DEV'(1) << w_head.dev;
                    w_op_nxt      = w_head.op;
                    w_digit_nxt   = w_head.digit;
                end
            end
            S_REQ: begin
                if (dev_ack[r_dev_sel]) begin
                    w_state_nxt = S_IDLE;
                    w_tmo_nxt   = '0;
                    w_req_nxt   = '0;
                    w_op_nxt    = '0;
                    w_digit_nxt = '0;
                end else if (w_tmo_inc == TMO_W'(ACK_TIMEOUT)) begin
                    w_state_nxt   = S_IDLE;
                    w_timeout_hit = 1'b1;
                    w_tmo_nxt     = '0;
                    w_req_nxt     = '0;
                    w_op_nxt      = '0;
                    w_digit_nxt   = '0;
                end else begin
                    w_tmo_nxt = w_tmo_inc;
                end
            end
            default: begin
                w_state_nxt = S_IDLE;
                w_req_nxt   = '0;
                w_op_nxt    = '0;
                w_digit_nxt = '0;
                w_tmo_nxt   = '0;
            end
        endcase
    end

    // Handshake output registers
    always_ff @(posedge clk) begin
        if (rst) begin
            r_tmo_cnt   <= '0;
            r_dev_sel   <= '0;
            r_dev_req   <= '0;
            r_dev_op    <= '0;
            r_dev_digit <= '0;
        end else begin
            r_tmo_cnt   <= w_tmo_nxt;
            r_dev_sel   <= w_dev_sel_nxt;
            r_dev_req   <= w_req_nxt;
            r_dev_op    <= w_op_nxt;
            r_dev_digit <= w_digit_nxt;
        end
    end

    // Status pulses and levels, computed from next-cycle values so they align with dev_req
    always_ff @(posedge clk) begin
        if (rst) begin
            r_cmd_dropped <= 1'b0;
            r_ack_timeout <= 1'b0;
            r_busy        <= 1'b0;
            r_dli         <= 1'b0;
        end else begin
            r_cmd_dropped <= w_any_rise && (w_multi_rise || w_full);
            r_ack_timeout <= w_timeout_hit;
            r_busy        <= (w_state_nxt != S_IDLE) || (w_count_nxt != '0);
            r_dli         <= (w_state_nxt == S_REQ) && (w_op_nxt == OP_LOAD);
        end
    end

    assign dev_req              = r_dev_req;
    assign dev_op               = r_dev_op;
    assign dev_digit            = r_dev_digit;
    assign cmd_dropped          = r_cmd_dropped;
    assign ack_timeout          = r_ack_timeout;
    assign fifo_count           = r_count;
    assign busy                 = r_busy;
    assign digit_load_indicator = r_dli;

endmodule

// File: tb/tb_device_cmd_scheduler.sv
// Bench for device_cmd_scheduler: directed scenarios followed by random traffic,
// every cycle compared against a queue-based reference model.
module tb_device_cmd_scheduler;

    localparam int unsigned NUM_DEV     = 4;
    localparam int unsigned SEL_W       = 2;
    localparam int unsigned DIGIT_W     = 7;
    localparam int unsigned FIFO_DEPTH  = 4;
    localparam int unsigned ACK_TIMEOUT = 15;

    logic                 clk = 1'b0;
    logic                 rst;
    logic [SEL_W-1:0]     device_choice;
    logic [DIGIT_W-1:0]   digit_choice;
    logic                 digit_load;
    logic                 digit_change;
    logic                 mode_change;
    logic [NUM_DEV-1:0]   dev_req;
    logic [1:0]           dev_op;
    logic [DIGIT_W-1:0]   dev_digit;
    logic [NUM_DEV-1:0]   dev_ack;
    logic                 cmd_dropped;
    logic                 ack_timeout;
    logic [2:0]           fifo_count;
    logic                 busy;
    logic                 digit_load_indicator;

    int vectors     = 0;
    int miscompares = 0;

    always #5 clk = ~clk;

    device_cmd_scheduler #(
        .NUM_DEV(NUM_DEV), .SEL_W(SEL_W), .DIGIT_W(DIGIT_W),
        .FIFO_DEPTH(FIFO_DEPTH), .ACK_TIMEOUT(ACK_TIMEOUT)
    ) dut (
        .clk(clk), .rst(rst),
        .device_choice(device_choice), .digit_choice(digit_choice),
        .digit_load(digit_load), .digit_change(digit_change), .mode_change(mode_change),
        .dev_req(dev_req), .dev_op(dev_op), .dev_digit(dev_digit), .dev_ack(dev_ack),
        .cmd_dropped(cmd_dropped), .ack_timeout(ack_timeout), .fifo_count(fifo_count),
        .busy(busy), .digit_load_indicator(digit_load_indicator)
    );

    // Reference model: a queue of pending commands plus the one in flight
    typedef struct packed {
        logic [1:0]         op;
        logic [SEL_W-1:0]   dev;
        logic [DIGIT_W-1:0] digit;
    } ent_t;

    ent_t m_q[$];
    ent_t m_cur;
    bit   m_active = 1'b0;
    int   m_age    = 0;
    bit   m_hist_mode, m_hist_load, m_hist_chg;
    bit   e_drop   = 1'b0;
    bit   e_tmo    = 1'b0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp)
        else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Apply one clock edge to the model using the inputs the DUT sees at that edge
    task automatic model_edge();
        ent_t e;
        bit   rm, rl, rc, full;
        int   nr;
        if (rst) begin
            m_hist_mode = 1'b1; m_hist_load = 1'b1; m_hist_chg = 1'b1;
            m_q.delete();
            m_active = 1'b0;
            m_age    = 0;
            e_drop   = 1'b0;
            e_tmo    = 1'b0;
        end else begin
            rm   = mode_change  && !m_hist_mode;
            rl   = digit_load   && !m_hist_load;
            rc   = digit_change && !m_hist_chg;
            nr   = int'(rm) + int'(rl) + int'(rc);
            full = (m_q.size() == FIFO_DEPTH);
            e_drop = 1'b0;
            e_tmo  = 1'b0;
            if (m_active) begin
                if (dev_ack[m_cur.dev] === 1'b1) begin
                    m_active = 1'b0;
                end else begin
                    m_age++;
                    if (m_age == ACK_TIMEOUT) begin
                        m_active = 1'b0;
                        e_tmo    = 1'b1;
                    end
                end
            end else if (m_q.size() > 0) begin
                m_cur    = m_q.pop_front();
                m_active = 1'b1;
                m_age    = 0;
            end
            if (nr > 0) begin
                if (full) begin
                    e_drop = 1'b1;
                end else begin
                    e.op    = rm ? 2'b10 : (rl ? 2'b00 : 2'b01);
                    e.dev   = device_choice;
                    e.digit = digit_choice;
                    m_q.push_back(e);
                end
                if (nr > 1) e_drop = 1'b1;
            end
            m_hist_mode = mode_change;
            m_hist_load = digit_load;
            m_hist_chg  = digit_change;
        end
    endtask

    task automatic check_all();
        logic [NUM_DEV-1:0] one;
        logic [NUM_DEV-1:0] ereq;
        one  = NUM_DEV'(1);
        ereq = m_active ? (one << m_cur.dev) : '0;
        chk("dev_req",     32'(dev_req),     32'(ereq));
        chk("dev_op",      32'(dev_op),      m_active ? 32'(m_cur.op) : 32'd0);
        chk("dev_digit",   32'(dev_digit),   m_active ? 32'(m_cur.digit) : 32'd0);
        chk("cmd_dropped", 32'(cmd_dropped), 32'(e_drop));
        chk("ack_timeout", 32'(ack_timeout), 32'(e_tmo));
        chk("fifo_count",  32'(fifo_count),  32'(m_q.size()));
        chk("busy",        32'(busy),        32'(m_active || (m_q.size() > 0)));
        chk("dli",         32'(digit_load_indicator), 32'(m_active && (m_cur.op == 2'b00)));
    endtask

    task automatic tick();
        @(posedge clk);
        model_edge();
        #1;
        check_all();
    endtask

    // One button press to device d: rising edge then release
    task automatic press_load(input logic [SEL_W-1:0] d, input logic [DIGIT_W-1:0] g);
        device_choice = d;
        digit_choice  = g;
        digit_load    = 1'b1;
        tick();
        digit_load    = 1'b0;
        tick();
    endtask

    initial begin
        int lat;
        int pulses;
        int last;
        rst = 1'b1; device_choice = '0; digit_choice = '0;
        digit_load = 1'b1; digit_change = 1'b0; mode_change = 1'b0; dev_ack = '0;

        // 1: button held through reset fires nothing
        repeat (3) tick();
        rst = 1'b0;
        tick();
        tick();
        chk("t1_count", 32'(fifo_count), 32'd0);
        chk("t1_req",   32'(dev_req),    32'd0);
        chk("t1_busy",  32'(busy),       32'd0);
        digit_load = 1'b0;
        tick();

        // 2: load to device 1, ack two cycles after request
        device_choice = 2'b01; digit_choice = 7'h01; digit_load = 1'b1;
        tick();
        chk("t2_queued", 32'(fifo_count), 32'd1);
        chk("t2_req_n",  32'(dev_req),    32'd0);
        digit_load = 1'b0;
        tick();
        chk("t2_req",   32'(dev_req),   32'b0010);
        chk("t2_op",    32'(dev_op),    32'd0);
        chk("t2_digit", 32'(dev_digit), 32'h01);
        chk("t2_dli",   32'(digit_load_indicator), 32'd1);
        tick();
        dev_ack = 4'b0010;
        tick();
        dev_ack = '0;
        chk("t2_req_off",   32'(dev_req),   32'd0);
        chk("t2_dli_off",   32'(digit_load_indicator), 32'd0);
        chk("t2_digit_off", 32'(dev_digit), 32'd0);
        chk("t2_busy_off",  32'(busy),      32'd0);

        // 3: mode and change together, mode wins and the loser is reported
        device_choice = 2'b11; digit_choice = 7'h33;
        mode_change = 1'b1; digit_change = 1'b1;
        tick();
        chk("t3_count", 32'(fifo_count),  32'd1);
        chk("t3_drop",  32'(cmd_dropped), 32'd1);
        mode_change = 1'b0; digit_change = 1'b0;
        tick();
        chk("t3_drop_end", 32'(cmd_dropped), 32'd0);
        chk("t3_req",      32'(dev_req),     32'b1000);
        chk("t3_op",       32'(dev_op),      32'b10);
        dev_ack = 4'b1000;
        tick();
        dev_ack = '0;

        // 4: no acks, six presses fill the queue and the sixth is dropped
        for (int i = 0; i < 5; i++) press_load(2'b00, 7'(i + 16));
        device_choice = 2'b00; digit_choice = 7'h7f; digit_load = 1'b1;
        tick();
        chk("t4_drop",  32'(cmd_dropped), 32'd1);
        chk("t4_full",  32'(fifo_count),  32'd4);
        digit_load = 1'b0;
        pulses = 0; last = 0;
        for (int k = 1; k <= 100; k++) begin
            tick();
            if (ack_timeout === 1'b1) begin
                if (pulses > 0) chk("t4_period", 32'(k - last), 32'(ACK_TIMEOUT + 1));
                last = k;
                pulses++;
            end
        end
        chk("t4_pulses", 32'(pulses), 32'd5);
        chk("t4_idle",   32'(busy),   32'd0);

        // 5: ack from a different device is ignored until timeout
        device_choice = 2'b01; digit_choice = 7'h55; digit_change = 1'b1;
        tick();
        digit_change = 1'b0;
        dev_ack = 4'b0100;
        tick();
        chk("t5_req", 32'(dev_req), 32'b0010);
        lat = 0;
        for (int k = 1; k <= 40; k++) begin
            tick();
            if (ack_timeout === 1'b1) begin
                lat = k;
                break;
            end
            chk("t5_hold", 32'(dev_req), 32'b0010);
        end
        chk("t5_latency", 32'(lat),     32'(ACK_TIMEOUT));
        chk("t5_req_off", 32'(dev_req), 32'd0);
        dev_ack = '0;
        tick();

        // 6: reset during a request with two entries waiting
        for (int i = 0; i < 3; i++) press_load(2'b10, 7'(i + 64));
        chk("t6_pre_count", 32'(fifo_count), 32'd2);
        chk("t6_pre_req",   32'(dev_req),    32'b0100);
        rst = 1'b1;
        tick();
        chk("t6_req",   32'(dev_req),     32'd0);
        chk("t6_count", 32'(fifo_count),  32'd0);
        chk("t6_busy",  32'(busy),        32'd0);
        chk("t6_tmo",   32'(ack_timeout), 32'd0);
        rst = 1'b0;
        repeat (20) tick();

        // Random traffic against the model
        for (int n = 0; n < 1500; n++) begin
            mode_change   = ($urandom_range(0, 5) == 0);
            digit_load    = ($urandom_range(0, 3) == 0);
            digit_change  = ($urandom_range(0, 3) == 0);
            device_choice = SEL_W'($urandom_range(0, NUM_DEV - 1));
            digit_choice  = DIGIT_W'($urandom);
            for (int d = 0; d < NUM_DEV; d++) dev_ack[d] = ($urandom_range(0, 7) == 0);
            rst = ($urandom_range(0, 249) == 0);
            tick();
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
